// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared types, defaults and helpers for the UART RX frame controller
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam int DEF_CLKS_PER_BIT = 16;
    localparam int DEF_DATA_BITS    = 8;

    // Reverse the low n bits of v; bits at and above n come back as 0.
    function automatic logic [31:0] bit_reverse(input logic [31:0] v, input int n);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < n) begin
                r[5'(i)] = v[5'(n - 1 - i)];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop RX synchroniser with reset-to-idle and falling-edge detect
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    output logic rx_s,
    output logic rx_fall
);

    logic rx_m;
    logic rx_d;

    // Metastability chain plus one delayed copy; all reset to the idle (high) line level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            rx_d <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
            rx_d <= rx_s;
        end
    end

    assign rx_fall = rx_d & ~rx_s;

endmodule

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART RX frame controller; define UART_RX_PARITY_EN to add a parity bit
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int DATA_BITS    = DEF_DATA_BITS,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 RX,
    input  logic [DATA_BITS-1:0] SR_DATA,
    output logic                 SHIFT_EN,
    output logic                 SHIFT_BIT,
    output logic [DATA_BITS-1:0] RX_DATA,
    output logic                 RX_VALID,
    input  logic                 RX_READY,
    output logic                 FRAME_ERR,
    output logic                 PARITY_ERR,
    output logic                 OVERRUN,
    output logic                 BUSY
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int CW = $clog2(DATA_BITS + 1);
    localparam logic [BW-1:0] BAUD_HALF = BW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(DATA_BITS - 1);

    logic            rx_s;
    logic            rx_fall;
    rx_state_t       state;
    logic [BW-1:0]   baud_cnt;
    logic [CW-1:0]   bit_cnt;
    logic            keep_word;

    uart_rx_sync u_sync (
        .clk     (CLK),
        .rst     (RST),
        .rx      (RX),
        .rx_s    (rx_s),
        .rx_fall (rx_fall)
    );

`ifdef UART_RX_PARITY_EN
    logic par_acc;
    logic word_bad;

    // Running XOR of the data bits and a sticky flag that vetoes delivery after a parity miss.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            par_acc    <= 1'b0;
            word_bad   <= 1'b0;
            PARITY_ERR <= 1'b0;
        end else begin
            PARITY_ERR <= 1'b0;
            if (state == START) begin
                par_acc  <= 1'b0;
                word_bad <= 1'b0;
            end else if (state == DATA && baud_cnt == BAUD_LAST) begin
                par_acc <= par_acc ^ rx_s;
            end else if (state == PARITY && baud_cnt == BAUD_LAST) begin
                if (rx_s != (par_acc ^ PARITY_ODD[0])) begin
                    PARITY_ERR <= 1'b1;
                    word_bad   <= 1'b1;
                end
            end
        end
    end

    assign keep_word = ~word_bad;
`else
    assign PARITY_ERR = 1'b0;
    assign keep_word  = 1'b1;
`endif

    // Frame FSM with registered strobes, output word register and valid/ready handshake.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            SHIFT_EN  <= 1'b0;
            SHIFT_BIT <= 1'b0;
            RX_DATA   <= '0;
            RX_VALID  <= 1'b0;
            FRAME_ERR <= 1'b0;
            OVERRUN   <= 1'b0;
            BUSY      <= 1'b0;
        end else begin
            SHIFT_EN  <= 1'b0;
            FRAME_ERR <= 1'b0;
            OVERRUN   <= 1'b0;
            if (RX_VALID && RX_READY) begin
                RX_VALID <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (rx_fall) begin
                        state    <= START;
                        baud_cnt <= '0;
                        BUSY     <= 1'b1;
                    end
                end

                START: begin
                    if (baud_cnt == BAUD_HALF) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        if (!rx_s) begin
                            state <= DATA;
                        end else begin
                            state <= IDLE;
                            BUSY  <= 1'b0;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (baud_cnt == BAUD_LAST) begin
                        SHIFT_EN  <= 1'b1;
                        SHIFT_BIT <= rx_s;
                        baud_cnt  <= '0;
                        bit_cnt   <= bit_cnt + 1'b1;
                        if (bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        state    <= STOP;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`endif

                STOP: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        state    <= IDLE;
                        BUSY     <= 1'b0;
                        if (!rx_s) begin
                            FRAME_ERR <= 1'b1;
                        end else if (keep_word) begin
                            if (!RX_VALID || RX_READY) begin
                                RX_DATA  <= DATA_BITS'(bit_reverse(32'(SR_DATA), DATA_BITS));
                                RX_VALID <= 1'b1;
                            end else begin
                                OVERRUN <= 1'b1;
                            end
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                default: begin
                    state    <= IDLE;
                    baud_cnt <= '0;
                    BUSY     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - directed self-checking bench for uart_rx_ctrl
module tb_uart_rx_ctrl;

    localparam int CPB = 16;
    localparam int NB  = 8;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          RX = 1'b1;
    logic [NB-1:0] SR_DATA;
    logic          SHIFT_EN;
    logic          SHIFT_BIT;
    logic [NB-1:0] RX_DATA;
    logic          RX_VALID;
    logic          RX_READY = 1'b1;
    logic          FRAME_ERR;
    logic          PARITY_ERR;
    logic          OVERRUN;
    logic          BUSY;

    int errors = 0;
    int checks = 0;

    uart_rx_ctrl #(.CLKS_PER_BIT(CPB), .DATA_BITS(NB), .PARITY_ODD(0)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX         (RX),
        .SR_DATA    (SR_DATA),
        .SHIFT_EN   (SHIFT_EN),
        .SHIFT_BIT  (SHIFT_BIT),
        .RX_DATA    (RX_DATA),
        .RX_VALID   (RX_VALID),
        .RX_READY   (RX_READY),
        .FRAME_ERR  (FRAME_ERR),
        .PARITY_ERR (PARITY_ERR),
        .OVERRUN    (OVERRUN),
        .BUSY       (BUSY)
    );

    always #5 CLK = ~CLK;

    // External shift register: first received bit ends up at the MSB.
    logic [NB-1:0] sr = '0;
    always @(posedge CLK) begin
        if (SHIFT_EN) sr <= {sr[NB-2:0], SHIFT_BIT};
    end
    assign SR_DATA = sr;

    // Event monitor, sampled on the falling edge; counters only ever grow.
    int cyc = 0;
    int n_shift = 0;
    int n_vrise = 0;
    int n_vhigh = 0;
    int n_ferr = 0;
    int n_perr = 0;
    int n_ovr = 0;
    int n_busy = 0;
    int st_t [0:255];
    logic st_b [0:255];
    logic prev_valid = 1'b0;
    always @(negedge CLK) begin
        cyc = cyc + 1;
        if (SHIFT_EN && n_shift < 256) begin
            st_t[n_shift] = cyc;
            st_b[n_shift] = SHIFT_BIT;
            n_shift = n_shift + 1;
        end
        if (RX_VALID && !prev_valid) n_vrise = n_vrise + 1;
        if (RX_VALID) n_vhigh = n_vhigh + 1;
        if (FRAME_ERR) n_ferr = n_ferr + 1;
        if (PARITY_ERR) n_perr = n_perr + 1;
        if (OVERRUN) n_ovr = n_ovr + 1;
        if (BUSY) n_busy = n_busy + 1;
        prev_valid = RX_VALID;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        RX = b;
        repeat (CPB) @(negedge CLK);
    endtask

    // Start bit, LSB-first data, optional parity bit (par < 0 means none), stop bit, short idle.
    task automatic send_frame(input logic [7:0] d, input logic stop_b, input int par);
        drive_bit(1'b0);
        for (int i = 0; i < NB; i++) drive_bit(d[i]);
        if (par >= 0) drive_bit(par[0]);
        drive_bit(stop_b);
        RX = 1'b1;
        repeat (8) @(negedge CLK);
    endtask

    int par_none;
    int b_shift, b_vrise, b_vhigh, b_ferr, b_perr, b_ovr, b_busy;
    int gmin, gmax;
    logic [7:0] bits_seen;

    task automatic snap();
        b_shift = n_shift; b_vrise = n_vrise; b_vhigh = n_vhigh;
        b_ferr = n_ferr; b_perr = n_perr; b_ovr = n_ovr; b_busy = n_busy;
    endtask

    initial begin
`ifdef UART_RX_PARITY_EN
        par_none = 0;
`else
        par_none = -1;
`endif
        repeat (3) @(negedge CLK);
        #1;
        check("rst_shift_en", 32'(SHIFT_EN), 32'd0);
        check("rst_valid", 32'(RX_VALID), 32'd0);
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_data", 32'(RX_DATA), 32'd0);
        RST = 1'b0;
        repeat (4) @(negedge CLK);

        // 0xA5 with consumer always ready; for even parity the parity bit is 0.
        snap();
        send_frame(8'hA5, 1'b1, par_none);
        check("a5_strobes", 32'(n_shift - b_shift), 32'd8);
        bits_seen = '0;
        gmin = 1000; gmax = 0;
        for (int i = 0; i < 8; i++) begin
            bits_seen = {bits_seen[6:0], st_b[b_shift + i]};
            if (i > 0) begin
                if (st_t[b_shift + i] - st_t[b_shift + i - 1] < gmin) gmin = st_t[b_shift + i] - st_t[b_shift + i - 1];
                if (st_t[b_shift + i] - st_t[b_shift + i - 1] > gmax) gmax = st_t[b_shift + i] - st_t[b_shift + i - 1];
            end
        end
        check("a5_bit_order", 32'(bits_seen), 32'hA5);
        check("a5_gap_min", 32'(gmin), 32'd16);
        check("a5_gap_max", 32'(gmax), 32'd16);
        check("a5_data", 32'(RX_DATA), 32'hA5);
        check("a5_valid_cycles", 32'(n_vhigh - b_vhigh), 32'd1);
        check("a5_errs", 32'((n_ferr - b_ferr) + (n_perr - b_perr) + (n_ovr - b_ovr)), 32'd0);

        // 4-cycle low glitch must be rejected in START.
        snap();
        RX = 1'b0;
        repeat (4) @(negedge CLK);
        RX = 1'b1;
        repeat (CPB / 2) @(negedge CLK);
        check("glitch_busy_low", 32'(BUSY), 32'd0);
        check("glitch_busy_seen", 32'(n_busy - b_busy > 0), 32'd1);
        repeat (20) @(negedge CLK);
        check("glitch_no_shift", 32'(n_shift - b_shift), 32'd0);
        check("glitch_no_err", 32'((n_ferr - b_ferr) + (n_vrise - b_vrise)), 32'd0);

        // 0x3C with a low stop bit, then a clean 0x3C (parity of 0x3C is 0).
        snap();
        send_frame(8'h3C, 1'b0, par_none);
        check("ferr_pulse", 32'(n_ferr - b_ferr), 32'd1);
        check("ferr_no_valid", 32'(n_vrise - b_vrise), 32'd0);
        snap();
        send_frame(8'h3C, 1'b1, par_none);
        check("after_ferr_data", 32'(RX_DATA), 32'h3C);
        check("after_ferr_valid", 32'(n_vrise - b_vrise), 32'd1);

        // Overrun: 0x11 then 0x22 with the consumer stalled (both have even bit count).
        RX_READY = 1'b0;
        snap();
        send_frame(8'h11, 1'b1, par_none);
        send_frame(8'h22, 1'b1, par_none);
        check("ovr_valid_held", 32'(RX_VALID), 32'd1);
        check("ovr_data_kept", 32'(RX_DATA), 32'h11);
        check("ovr_pulse", 32'(n_ovr - b_ovr), 32'd1);
        RX_READY = 1'b1;
        @(negedge CLK);
        check("ovr_valid_drop", 32'(RX_VALID), 32'd0);

        // Reset in the middle of data bits, then 0xF0 (parity 0).
        snap();
        drive_bit(1'b0);
        drive_bit(1'b1); drive_bit(1'b0); drive_bit(1'b1); drive_bit(1'b0);
        repeat (4) @(negedge CLK);
        check("mid_rst_strobes", 32'(n_shift - b_shift), 32'd4);
        RST = 1'b1;
        RX = 1'b1;
        #1;
        check("mid_rst_outputs", 32'({SHIFT_EN, RX_VALID, FRAME_ERR, OVERRUN, BUSY, PARITY_ERR}), 32'd0);
        check("mid_rst_data", 32'(RX_DATA), 32'd0);
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        repeat (4) @(negedge CLK);
        snap();
        send_frame(8'hF0, 1'b1, par_none);
        check("f0_data", 32'(RX_DATA), 32'hF0);
        check("f0_valid", 32'(n_vrise - b_vrise), 32'd1);
        check("f0_no_ferr", 32'(n_ferr - b_ferr), 32'd0);

`ifdef UART_RX_PARITY_EN
        // 0x07 has three ones: even parity bit is 1.
        snap();
        send_frame(8'h07, 1'b1, 1);
        check("par_ok_data", 32'(RX_DATA), 32'h07);
        check("par_ok_valid", 32'(n_vrise - b_vrise), 32'd1);
        check("par_ok_no_perr", 32'(n_perr - b_perr), 32'd0);
        snap();
        send_frame(8'h07, 1'b1, 0);
        check("par_bad_pulse", 32'(n_perr - b_perr), 32'd1);
        check("par_bad_no_valid", 32'(n_vrise - b_vrise), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
